// File: rtl/key_debounce_bank_if.sv
// Key bank signal bundle: raw key inputs in, debounced level and one-cycle strobes out.
interface key_debounce_bank_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;

  modport master (
    output key_in,
    input  key_level, key_press, key_release, key_repeat
  );

  modport slave (
    input  key_in,
    output key_level, key_press, key_release, key_repeat
  );
endinterface

// File: rtl/key_debounce_bank.sv
// N-key debouncer: 2-flop sync, stability filter, press/release strobes and optional auto-repeat.
// A clean input change reaches key_level STABLE_CYCLES+2 edges after first sampling; strobes are free-running, no backpressure.
module key_debounce_bank #(
  parameter int N_KEYS        = 4,
  parameter int STABLE_CYCLES = 1048575,
  parameter int ACTIVE_LOW    = 0,
  parameter int REPEAT_EN     = 1,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input logic                clk,
  input logic                RESET,
  key_debounce_bank_if.slave kif
);
  localparam int CNT_W  = $clog2(STABLE_CYCLES);
  localparam int HC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HC_W   = (HC_MAX > 1) ? $clog2(HC_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0]  RPT_LAST  = HC_W'(REPEAT_CYCLES - 1);
  localparam logic             POL       = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_RPT} rpt_state_e;

  logic [N_KEYS-1:0] level_vec;
  logic [N_KEYS-1:0] press_vec;
  logic [N_KEYS-1:0] rel_vec;
  logic [N_KEYS-1:0] rep_vec;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    always_comb begin
      s1_d    = kif.key_in[i] ^ POL;
      s2_d    = s1_q;
      prev_d  = s2_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      // Any difference between consecutive synchronised samples restarts the window.
      if (s2_q != prev_q) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if ((s2_q == prev_q) && (cnt_q == CNT_MAX) && (s2_q != level_q)) begin
        level_d = s2_q;
        press_d = s2_q;
        rel_d   = ~s2_q;
      end
    end

    always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        prev_q  <= 1'b0;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        s1_q    <= s1_d;
        s2_q    <= s2_d;
        prev_q  <= prev_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign level_vec[i] = level_q;
    assign press_vec[i] = press_q;
    assign rel_vec[i]   = rel_q;

    if (REPEAT_EN != 0) begin : g_rpt
      rpt_state_e      st_q, st_d;
      logic [HC_W-1:0] hc_q, hc_d;
      logic            rep_q, rep_d;

      always_comb begin
        st_d  = st_q;
        hc_d  = hc_q + HC_W'(1);
        rep_d = 1'b0;
        case (st_q)
          ST_IDLE: begin
            hc_d = '0;
            if (press_d) st_d = ST_HOLD;
          end
          ST_HOLD: begin
            if (hc_q == HOLD_LAST) begin
              st_d  = ST_RPT;
              hc_d  = '0;
              rep_d = 1'b1;
            end
          end
          ST_RPT: begin
            if (hc_q == RPT_LAST) begin
              hc_d  = '0;
              rep_d = 1'b1;
            end
          end
          default: begin
            st_d = ST_IDLE;
            hc_d = '0;
          end
        endcase
        // Release wins over a repeat falling due on the same edge.
        if (rel_d) begin
          st_d  = ST_IDLE;
          hc_d  = '0;
          rep_d = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
          st_q  <= ST_IDLE;
          hc_q  <= '0;
          rep_q <= 1'b0;
        end else begin
          st_q  <= st_d;
          hc_q  <= hc_d;
          rep_q <= rep_d;
        end
      end

      assign rep_vec[i] = rep_q;
    end else begin : g_no_rpt
      assign rep_vec[i] = 1'b0;
    end
  end

  assign kif.key_level   = level_vec;
  assign kif.key_press   = press_vec;
  assign kif.key_release = rel_vec;
  assign kif.key_repeat  = rep_vec;
endmodule
